// File: rtl/alu_pkg.sv
// Shared definitions for the sequential carry-lookahead adder/subtractor.
//   state_t        : control FSM encoding (IDLE, RUN, DONE)
//   DEF_WIDTH      : default operand/result width
//   DEF_SLICE      : default lookahead slice width (bits evaluated per clock)
//   MODE_ADD/SUB   : encoding of the sub input
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SLICE = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/cla_slice.sv
// Purely combinational SLICE-bit carry-lookahead adder slice.
// Ports:
//   i_a, i_b : slice operands
//   i_c      : carry into bit 0 of the slice
//   o_sum    : slice sum
//   o_c      : carry out of the slice MSB
//   o_c_msb  : carry into the slice MSB (used for signed overflow)
module cla_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_c,
  output logic [SLICE-1:0] o_sum,
  output logic             o_c,
  output logic             o_c_msb
);

  logic [SLICE-1:0] w_g;
  logic [SLICE-1:0] w_p;
  logic [SLICE:0]   w_carry;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is formed directly from generate/propagate terms rather than
  // chained from the previous carry: c[i+1] = OR_j (g[j] & p[j+1..i]) | (p[0..i] & c0).
  always_comb begin
    logic w_term;
    logic w_acc;
    w_term  = 1'b0;
    w_acc   = 1'b0;
    w_carry = '0;
    w_carry[0] = i_c;
    for (int i = 0; i < SLICE; i++) begin
      w_acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        w_term = w_g[j];
        for (int k = j + 1; k <= i; k++) begin
          w_term = w_term & w_p[k];
        end
        w_acc = w_acc | w_term;
      end
      w_term = i_c;
      for (int k = 0; k <= i; k++) begin
        w_term = w_term & w_p[k];
      end
      w_carry[i+1] = w_acc | w_term;
    end
  end

  assign o_sum   = w_p ^ w_carry[SLICE-1:0];
  assign o_c     = w_carry[SLICE];
  assign o_c_msb = w_carry[SLICE-1];

endmodule

// File: rtl/cla_addsub_seq.sv
// Multi-cycle adder/subtractor: one SLICE-bit lookahead slice is evaluated per
// clock, the inter-slice carry rippling through a register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : request, held high for the whole operation
//   sub        : 0 = add, 1 = subtract (captured)
//   A, B       : operands (captured)
//   c_in       : carry-in (add) / borrow-in (sub) (captured)
//   Output     : result, valid while ready=1
//   c_out      : raw carry out of MSB (sub: 1 = no borrow)
//   ovf, zero  : two's-complement overflow, result==0
//   ready      : result valid
module cla_addsub_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic [WIDTH-1:0] Output,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             ready
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

  if (((WIDTH % SLICE) != 0) || (WIDTH < SLICE)) begin : g_param_check
    $error("cla_addsub_seq: WIDTH must be a non-zero multiple of SLICE");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_ready;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_sum;
  logic             w_slc_c;
  logic             w_slc_c_msb;
  logic [WIDTH-1:0] w_final;

  assign w_a_sl = r_a[int'(r_idx)*SLICE +: SLICE];
  assign w_b_sl = r_b[int'(r_idx)*SLICE +: SLICE];

  // Single slice instance, time-multiplexed over slice index r_idx.
  cla_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .i_a     (w_a_sl),
    .i_b     (w_b_sl),
    .i_c     (r_carry),
    .o_sum   (w_sum),
    .o_c     (w_slc_c),
    .o_c_msb (w_slc_c_msb)
  );

  // Result as it will look after the current slice is written; used for the
  // zero flag on the last slice so the flag is registered with the result.
  always_comb begin
    w_final = r_out;
    w_final[int'(r_idx)*SLICE +: SLICE] = w_sum;
  end

  // Operand capture. Subtraction is A + ~B + ~borrow, so B is inverted here
  // and the carry register gets the inverted borrow at capture.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == IDLE) && en) begin
      r_a <= A;
      r_b <= (sub == MODE_SUB) ? ~B : B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (en) begin
            r_carry <= (sub == MODE_SUB) ? ~c_in : c_in;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Abort leaves result and flags untouched.
          if (!en) begin
            r_state <= IDLE;
          end else begin
            r_out[int'(r_idx)*SLICE +: SLICE] <= w_sum;
            r_carry <= w_slc_c;
            if (r_idx == LAST_IDX) begin
              r_cout  <= w_slc_c;
              r_ovf   <= w_slc_c_msb ^ w_slc_c;
              r_zero  <= (w_final == '0);
              r_ready <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (!en) begin
            r_ready <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Output = r_out;
  assign c_out  = r_cout;
  assign ovf    = r_ovf;
  assign zero   = r_zero;
  assign ready  = r_ready;

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Directed bench for cla_addsub_seq at WIDTH=8, SLICE=4 with hand-computed results.
module tb_cla_addsub_seq;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sub;
  logic [7:0] A;
  logic [7:0] B;
  logic       c_in;
  logic [7:0] Output;
  logic       c_out;
  logic       ovf;
  logic       zero;
  logic       ready;

  int n_cmp;
  int n_err;

  cla_addsub_seq #(
    .WIDTH (8),
    .SLICE (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sub    (sub),
    .A      (A),
    .B      (B),
    .c_in   (c_in),
    .Output (Output),
    .c_out  (c_out),
    .ovf    (ovf),
    .zero   (zero),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full operation: capture, check 2-cycle latency, result, hold in DONE, release.
  task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic ci, input bit scramble,
                       input logic [7:0] e_out, input logic e_c, input logic e_v,
                       input logic e_z);
    @(negedge clk);
    en = 1'b1; A = a; B = b; sub = s; c_in = ci;
    @(posedge clk);
    @(negedge clk);
    chk({name, ".ready_k0"}, 32'(ready), 32'd0);
    if (scramble) begin
      A = ~a; B = ~b; sub = ~s; c_in = ~ci;
    end
    @(posedge clk);
    @(negedge clk);
    chk({name, ".ready_k1"}, 32'(ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({name, ".ready"}, 32'(ready), 32'd1);
    chk({name, ".out"},   32'(Output), 32'(e_out));
    chk({name, ".c_out"}, 32'(c_out), 32'(e_c));
    chk({name, ".ovf"},   32'(ovf), 32'(e_v));
    chk({name, ".zero"},  32'(zero), 32'(e_z));
    @(posedge clk);
    @(negedge clk);
    chk({name, ".hold_ready"}, 32'(ready), 32'd1);
    chk({name, ".hold_out"},   32'(Output), 32'(e_out));
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({name, ".release"}, 32'(ready), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b0; sub = 1'b0; A = '0; B = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.out",   32'(Output), 32'd0);
    chk("rst.c_out", 32'(c_out), 32'd0);
    chk("rst.ovf",   32'(ovf), 32'd0);
    chk("rst.zero",  32'(zero), 32'd0);
    chk("rst.ready", 32'(ready), 32'd0);

    do_op("add",  8'h3A, 8'h47, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
    do_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Abort after one RUN edge: ready never rises, flags from "wrap" remain.
    @(negedge clk);
    en = 1'b1; A = 8'h3A; B = 8'h47; sub = 1'b0; c_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort.ready", 32'(ready), 32'd0);
    end
    chk("abort.c_out", 32'(c_out), 32'd1);
    chk("abort.ovf",   32'(ovf), 32'd0);
    chk("abort.zero",  32'(zero), 32'd1);

    do_op("sub",    8'h10, 8'h01, 1'b1, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0);
    do_op("borrow", 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    do_op("scram",  8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0, 1'b0);
    do_op("subovf", 8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b1, 1'b0);

    // Reset one edge after capture.
    @(negedge clk);
    en = 1'b1; A = 8'h55; B = 8'h22; sub = 1'b0; c_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    chk("midrst.out",   32'(Output), 32'd0);
    chk("midrst.c_out", 32'(c_out), 32'd0);
    chk("midrst.ovf",   32'(ovf), 32'd0);
    chk("midrst.zero",  32'(zero), 32'd0);
    chk("midrst.ready", 32'(ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst.ready2", 32'(ready), 32'd0);

    do_op("recover", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
